// File: rtl/regfile_scb.sv
// regfile_scb -- register file with per-register busy (pending-write) scoreboard.
//
// Holds NREG = 2**AW registers of DW bits. It has one write port and two
// combinational read ports. Each register also has a busy bit. "mark" sets the
// bit when a multi-cycle op is issued, and a write to that register clears it.
//
// Parameters:
//   DW       data width
//   AW       address width (NREG = 2**AW)
//   BYPASS   1: a same-cycle write is forwarded to the read ports
//   ZERO_R0  1: register 0 reads as zero and ignores writes and marks
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset (clears data and busy bits)
//   we, waddr, wdata    write port
//   raddr1, raddr2      read addresses
//   rdata1, rdata2      read data (combinational)
//   mark, mark_addr     set busy bit of mark_addr
//   busy1, busy2        busy status of raddr1 / raddr2 (combinational)
module regfile_scb #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    input  logic          mark,
    input  logic [AW-1:0] mark_addr,
    output logic          busy1,
    output logic          busy2
);

    localparam int unsigned NREG = 2 ** AW;

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;

    logic wr_ok;
    logic mark_ok;

    assign wr_ok   = we   && !(ZERO_R0 && (waddr == '0));
    assign mark_ok = mark && !(ZERO_R0 && (mark_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_ok) begin
                mem[waddr] <= wdata;
            end
            // A mark to the same register as the write wins, so the bit stays set.
            for (int unsigned i = 0; i < NREG; i++) begin
                if (mark_ok && (mark_addr == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (we && (waddr == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read port 1
    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (!rst_n) begin
            rdata1 = '0;
            busy1  = 1'b0;
        end else if (ZERO_R0 && (raddr1 == '0)) begin
            rdata1 = '0;
            busy1  = 1'b0;
        end else if (BYPASS && we && (raddr1 == waddr)) begin
            rdata1 = wdata;
            busy1  = mark && (mark_addr == raddr1);
        end else begin
            rdata1 = mem[raddr1];
            busy1  = busy[raddr1];
        end
    end

    // Read port 2
    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (!rst_n) begin
            rdata2 = '0;
            busy2  = 1'b0;
        end else if (ZERO_R0 && (raddr2 == '0)) begin
            rdata2 = '0;
            busy2  = 1'b0;
        end else if (BYPASS && we && (raddr2 == waddr)) begin
            rdata2 = wdata;
            busy2  = mark && (mark_addr == raddr2);
        end else begin
            rdata2 = mem[raddr2];
            busy2  = busy[raddr2];
        end
    end

endmodule
